// File: rtl/led_blinker_pkg.sv
// Shared types and default timing for the multi-channel LED blinker.
// Default half-periods assume a 25 MHz clock.
package led_blinker_pkg;

  typedef enum logic [1:0] {
    RATE_0 = 2'd0,
    RATE_1 = 2'd1,
    RATE_2 = 2'd2,
    RATE_3 = 2'd3
  } rate_sel_t;

  localparam int unsigned DEF_HALF_R0 = 125000;    // 100 Hz
  localparam int unsigned DEF_HALF_R1 = 250000;    // 50 Hz
  localparam int unsigned DEF_HALF_R2 = 1250000;   // 10 Hz
  localparam int unsigned DEF_HALF_R3 = 12500000;  // 1 Hz

  function automatic int unsigned max_half(input int unsigned a, input int unsigned b,
                                           input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Width able to hold max_val - 1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/blink_channel.sv
// One LED channel: half-period counter, phase bit and period-aligned rate register.
// Debug outputs exist only when MULTI_LED_BLINKER_DBG_EN is defined.
module blink_channel
  import led_blinker_pkg::*;
#(
  parameter int unsigned HALF_R0 = DEF_HALF_R0,
  parameter int unsigned HALF_R1 = DEF_HALF_R1,
  parameter int unsigned HALF_R2 = DEF_HALF_R2,
  parameter int unsigned HALF_R3 = DEF_HALF_R3,
  parameter int unsigned CNT_W   = cnt_width(max_half(HALF_R0, HALF_R1, HALF_R2, HALF_R3))
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_enable,
  input  logic [1:0] i_rate_sel,
  input  logic       i_sync,
  output logic       o_led_drive
`ifdef MULTI_LED_BLINKER_DBG_EN
  ,
  output logic       o_dbg_phase,
  output logic [1:0] o_dbg_rate
`endif
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_m1;
  logic             phase_q, phase_d;
  logic             led_q, led_d;
  rate_sel_t        rate_q, rate_d;
  logic             wrap;

  always_comb begin
    half_m1 = CNT_W'(HALF_R0 - 1);
    case (rate_q)
      RATE_0: half_m1 = CNT_W'(HALF_R0 - 1);
      RATE_1: half_m1 = CNT_W'(HALF_R1 - 1);
      RATE_2: half_m1 = CNT_W'(HALF_R2 - 1);
      RATE_3: half_m1 = CNT_W'(HALF_R3 - 1);
      default: half_m1 = CNT_W'(HALF_R0 - 1);
    endcase
  end

  // Rate is only reloaded when the counter restarts, so a half-period never changes length.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    rate_d  = rate_q;
    wrap    = (cnt_q >= half_m1);
    if (!i_enable || i_sync) begin
      cnt_d   = '0;
      phase_d = 1'b0;
      rate_d  = rate_sel_t'(i_rate_sel);
    end else if (wrap) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
      if (phase_q) begin
        rate_d = rate_sel_t'(i_rate_sel);
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    led_d = phase_d & i_enable;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      rate_q  <= RATE_0;
      led_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      rate_q  <= rate_d;
      led_q   <= led_d;
    end
  end

  assign o_led_drive = led_q;

`ifdef MULTI_LED_BLINKER_DBG_EN
  assign o_dbg_phase = phase_q;
  assign o_dbg_rate  = rate_q;
`endif

endmodule

// File: rtl/multi_led_blinker.sv
// NUM_CH independent square-wave LED drivers with four selectable rates and a shared sync.
// Define MULTI_LED_BLINKER_DBG_EN to expose raw phase bits and active rate registers.
module multi_led_blinker
  import led_blinker_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned HALF_R0 = DEF_HALF_R0,
  parameter int unsigned HALF_R1 = DEF_HALF_R1,
  parameter int unsigned HALF_R2 = DEF_HALF_R2,
  parameter int unsigned HALF_R3 = DEF_HALF_R3
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic [NUM_CH-1:0]   i_enable,
  input  logic [2*NUM_CH-1:0] i_rate_sel,
  input  logic                i_sync,
  output logic [NUM_CH-1:0]   o_led_drive
`ifdef MULTI_LED_BLINKER_DBG_EN
  ,
  output logic [NUM_CH-1:0]   o_dbg_phase,
  output logic [2*NUM_CH-1:0] o_dbg_rate
`endif
);

  localparam int unsigned MaxHalf = max_half(HALF_R0, HALF_R1, HALF_R2, HALF_R3);
  localparam int unsigned CntW    = cnt_width(MaxHalf);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
`ifdef MULTI_LED_BLINKER_DBG_EN
    blink_channel #(
      .HALF_R0 (HALF_R0),
      .HALF_R1 (HALF_R1),
      .HALF_R2 (HALF_R2),
      .HALF_R3 (HALF_R3),
      .CNT_W   (CntW)
    ) u_channel (
      .i_clock     (i_clock),
      .i_reset_n   (i_reset_n),
      .i_enable    (i_enable[n]),
      .i_rate_sel  (i_rate_sel[2*n +: 2]),
      .i_sync      (i_sync),
      .o_led_drive (o_led_drive[n]),
      .o_dbg_phase (o_dbg_phase[n]),
      .o_dbg_rate  (o_dbg_rate[2*n +: 2])
    );
`else
    blink_channel #(
      .HALF_R0 (HALF_R0),
      .HALF_R1 (HALF_R1),
      .HALF_R2 (HALF_R2),
      .HALF_R3 (HALF_R3),
      .CNT_W   (CntW)
    ) u_channel (
      .i_clock     (i_clock),
      .i_reset_n   (i_reset_n),
      .i_enable    (i_enable[n]),
      .i_rate_sel  (i_rate_sel[2*n +: 2]),
      .i_sync      (i_sync),
      .o_led_drive (o_led_drive[n])
    );
`endif
  end

endmodule

// File: tb/tb_multi_led_blinker.sv
// Directed bench for multi_led_blinker with NUM_CH=2 and half-periods 4/6/10/20.
module tb_multi_led_blinker;

  logic       i_clock;
  logic       i_reset_n;
  logic [1:0] i_enable;
  logic [3:0] i_rate_sel;
  logic       i_sync;
  logic [1:0] o_led_drive;

  int checks = 0;
  int errors = 0;

  multi_led_blinker #(
    .NUM_CH  (2),
    .HALF_R0 (4),
    .HALF_R1 (6),
    .HALF_R2 (10),
    .HALF_R3 (20)
  ) dut (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_enable    (i_enable),
    .i_rate_sel  (i_rate_sel),
    .i_sync      (i_sync),
    .o_led_drive (o_led_drive)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Step one clock and settle just after the edge.
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  // One disabled edge clears the channels and loads rates, then enable the chosen set.
  task automatic restart(input logic [1:0] en, input logic [3:0] rates);
    i_enable   = 2'b00;
    i_rate_sel = rates;
    i_sync     = 1'b0;
    tick();
    i_enable = en;
  endtask

  initial begin
    i_reset_n  = 1'b1;
    i_enable   = 2'b00;
    i_rate_sel = 4'b0000;
    i_sync     = 1'b0;
    #1 i_reset_n = 1'b0;
    #1 check_eq("reset_state", 32'(o_led_drive), 32'd0);
    tick();
    tick();
    check_eq("reset_hold", 32'(o_led_drive), 32'd0);

    // Rate 0 on ch0: low 4, high 4, repeating; ch1 idle.
    i_reset_n = 1'b1;
    i_enable  = 2'b01;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check_eq($sformatf("r0_wave_k%0d", k), 32'(o_led_drive), 32'((k / 4) % 2));
    end

    // Switch to rate 3 two cycles into the high half.
    restart(2'b01, 4'b0000);
    repeat (3) tick();
    check_eq("sw_low_e3", 32'(o_led_drive), 32'd0);
    tick();
    check_eq("sw_high_e4", 32'(o_led_drive), 32'd1);
    tick();
    tick();
    check_eq("sw_high_e6", 32'(o_led_drive), 32'd1);
    i_rate_sel = 4'b0011;
    tick();
    check_eq("sw_high_e7", 32'(o_led_drive), 32'd1);
    tick();
    check_eq("sw_low_e8", 32'(o_led_drive), 32'd0);
    for (int j = 1; j <= 19; j++) begin
      tick();
      check_eq($sformatf("sw_long_low_%0d", j), 32'(o_led_drive), 32'd0);
    end
    tick();
    check_eq("sw_high_e28", 32'(o_led_drive), 32'd1);

    // ch0 rate 1, ch1 rate 2, then sync after 37 clocks.
    restart(2'b11, 4'b1001);
    repeat (37) tick();
    check_eq("sync_pre", 32'(o_led_drive), 32'b10);
    i_sync = 1'b1;
    tick();
    i_sync = 1'b0;
    check_eq("sync_clear", 32'(o_led_drive), 32'b00);
    for (int j = 1; j <= 10; j++) begin
      tick();
      check_eq($sformatf("sync_rise_%0d", j), 32'(o_led_drive),
               32'({(j >= 10) ? 1'b1 : 1'b0, (j >= 6) ? 1'b1 : 1'b0}));
    end

    // Sync on the exact wrap edge suppresses the toggle.
    restart(2'b01, 4'b0000);
    repeat (3) tick();
    i_sync = 1'b1;
    tick();
    i_sync = 1'b0;
    check_eq("sync_wrap_low", 32'(o_led_drive), 32'd0);
    repeat (3) tick();
    check_eq("sync_wrap_still_low", 32'(o_led_drive), 32'd0);
    tick();
    check_eq("sync_wrap_rise", 32'(o_led_drive), 32'd1);

    // Drop enable while high, then re-enable.
    restart(2'b01, 4'b0000);
    repeat (4) tick();
    check_eq("dis_high", 32'(o_led_drive), 32'd1);
    tick();
    check_eq("dis_high2", 32'(o_led_drive), 32'd1);
    i_enable = 2'b00;
    tick();
    check_eq("dis_off", 32'(o_led_drive), 32'd0);
    i_enable = 2'b01;
    repeat (3) tick();
    check_eq("reen_low", 32'(o_led_drive), 32'd0);
    tick();
    check_eq("reen_high", 32'(o_led_drive), 32'd1);

    // Asynchronous reset mid-high, then a clean first period.
    restart(2'b01, 4'b0000);
    repeat (5) tick();
    check_eq("rst_pre_high", 32'(o_led_drive), 32'd1);
    #2 i_reset_n = 1'b0;
    #1 check_eq("rst_async", 32'(o_led_drive), 32'd0);
    tick();
    tick();
    check_eq("rst_held", 32'(o_led_drive), 32'd0);
    i_reset_n = 1'b1;
    repeat (3) tick();
    check_eq("rst_rel_low", 32'(o_led_drive), 32'd0);
    tick();
    check_eq("rst_rel_rise", 32'(o_led_drive), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
